// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin front end for one shared, fixed-latency
// signed multiplier. Requester ids ride a tag pipe alongside the multiplier.
// Products land in a show-ahead response FIFO. Issue is credit-limited so
// that FIFO cannot overflow.
// Optional build macro: MUL_ARB_PERF_EN adds issue/stall performance counters.
module booth_mult_arbiter #(
    parameter int N         = 32,
    parameter int NUM_REQ   = 4,
    parameter int MUL_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*N-1:0]          req_a,
    input  logic [NUM_REQ*N-1:0]          req_b,
    output logic [N-1:0]                  mul_a,
    output logic [N-1:0]                  mul_b,
    input  logic [2*N-1:0]                mul_p,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [2*N-1:0]                rsp_prod
`ifdef MUL_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int EW  = IDW + 2 * N;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           found;
    logic           can_issue;
    logic           issue;
    logic           pop;
    logic [CW-1:0]  credit_cnt;

    logic           tag_v  [MUL_LAT];
    logic [IDW-1:0] tag_id [MUL_LAT];

    logic [EW-1:0]  fifo_mem [RSP_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_cnt;
    logic           wr_en;

    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign wr_en     = tag_v[MUL_LAT-1];

    // A pop frees a slot this very edge, so it can fund an issue in the same
    // cycle; the FIFO still cannot overflow because the product arrives later.
    assign can_issue = (credit_cnt < CW'(RSP_DEPTH)) | pop;

    // Round-robin search: first valid requester at or after rr_ptr, cyclically.
    always_comb begin : arb_search
        int             idx;
        logic [IDW-1:0] idx_b;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_b = idx[IDW-1:0];
            if (!found && req_valid[idx_b]) begin
                grant = idx_b;
                found = 1'b1;
            end
        end
    end

    // Grant, issue and operand steering; reset forces the multiplier inputs idle.
    always_comb begin
        issue     = rst & found & can_issue;
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (issue) begin
            req_ready = NUM_REQ'(1) << grant;
            mul_a     = req_a[int'(grant)*N +: N];
            mul_b     = req_b[int'(grant)*N +: N];
        end
    end

    // Round-robin pointer advances past the winner only when it actually issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
        end
    end

    // Outstanding-work credit: products in the pipe plus entries in the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt <= '0;
        end else if (issue && !pop) begin
            credit_cnt <= credit_cnt + CW'(1);
        end else if (!issue && pop) begin
            credit_cnt <= credit_cnt - CW'(1);
        end
    end

    // Tag pipe mirrors the multiplier latency so ids meet their products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {tag_id[MUL_LAT-1], mul_p};
        end
    end

    // FIFO pointers and occupancy; simultaneous write and pop both take effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Show-ahead head of FIFO; zero while empty so reset values are clean.
    always_comb begin
        rsp_id   = '0;
        rsp_prod = '0;
        if (rsp_valid) begin
            {rsp_id, rsp_prod} = fifo_mem[rd_ptr];
        end
    end

`ifdef MUL_ARB_PERF_EN
    // Saturating issue and credit-stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if ((|req_valid) && !can_issue && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: directed vectors, scoreboard queue filled at
// issue time, independent monitor popping on every response handshake.
// Includes a 2-stage signed multiplier model standing in for the shared unit.
module tb_booth_mult_arbiter;

    localparam int N  = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*N-1:0]   req_a;
    logic [NR*N-1:0]   req_b;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic [2*N-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*N-1:0]    rsp_prod;
`ifdef MUL_ARB_PERF_EN
    logic [31:0]       perf_issue_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [65:0] sbq [$];
    logic [63:0] exp_p [NR];

    always #5 clk = ~clk;

    booth_mult_arbiter #(.N(N), .NUM_REQ(NR), .MUL_LAT(2), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
`ifdef MUL_ARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Shared multiplier model: two register stages, same reset as the arbiter.
    logic signed [63:0] mp1, mp2;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mp1 <= '0;
            mp2 <= '0;
        end else begin
            mp1 <= $signed(mul_a) * $signed(mul_b);
            mp2 <= mp1;
        end
    end
    assign mul_p = mp2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d prod=%h want no response", rsp_id, rsp_prod);
            end else begin
                logic [65:0] e;
                e = sbq.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e[65:64]));
                check("rsp_prod", rsp_prod, e[63:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic load_table();
        set_op(0, 32'd3, 32'd5);
        set_op(1, 32'hFFFF_FF9C, 32'd7);
        set_op(2, 32'd123456, 32'hFFFF_FFFE);
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic push(input int i, input logic [63:0] p);
        sbq.push_back({i[1:0], p});
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst       = 1'b0;
        sbq.delete();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (sbq.size() != 0 && n < 40) begin
            next_cycle();
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending want 0", name, sbq.size());
        end
    endtask

    initial begin
        exp_p[0] = 64'd15;
        exp_p[1] = 64'hFFFF_FFFF_FFFF_FD44;
        exp_p[2] = 64'hFFFF_FFFF_FFFC_3B80;
        exp_p[3] = 64'd1;

        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_prod", rsp_prod, 64'd0);
        next_cycle();
        next_cycle();
        rst = 1'b1;

        // Single request from requester 2: -7 * 6.
        rsp_ready = 1'b1;
        set_op(2, 32'hFFFF_FFF9, 32'd6);
        req_valid = 4'b0100;
        push(2, 64'hFFFF_FFFF_FFFF_FFD6);
        @(negedge clk);
        check("s1_req_ready", 64'(req_ready), 64'b0100);
        check("s1_mul_a", 64'(mul_a), 64'hFFFF_FFF9);
        check("s1_mul_b", 64'(mul_b), 64'd6);
        next_cycle();
        req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("s1_rsp_valid_c%0d", c), 64'(rsp_valid), (c == 3) ? 64'd1 : 64'd0);
            check($sformatf("s1_idle_mul_a_c%0d", c), 64'(mul_a), 64'd0);
            next_cycle();
        end
        drain("s1");

        // All requesters valid, consumer always ready: strict rotation.
        do_reset();
        load_table();
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            if (c < 8) push(c % 4, exp_p[c % 4]);
            @(negedge clk);
            check($sformatf("s2_req_ready_c%0d", c), 64'(req_ready),
                  (c < 8) ? (64'd1 << (c % 4)) : 64'd0);
            check($sformatf("s2_rsp_valid_c%0d", c), 64'(rsp_valid),
                  (c >= 3 && c < 11) ? 64'd1 : 64'd0);
            next_cycle();
        end
        drain("s2");

        // Backpressure: four credits fill, issue stalls, head holds steady.
        do_reset();
        load_table();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) push(c, exp_p[c]);
            @(negedge clk);
            check($sformatf("s3_req_ready_c%0d", c), 64'(req_ready),
                  (c < 4) ? (64'd1 << c) : 64'd0);
            if (c >= 3) begin
                check($sformatf("s3_hold_valid_c%0d", c), 64'(rsp_valid), 64'd1);
                check($sformatf("s3_hold_id_c%0d", c), 64'(rsp_id), 64'd0);
                check($sformatf("s3_hold_prod_c%0d", c), rsp_prod, 64'd15);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        for (int c = 10; c < 14; c++) begin
            push(c - 10, exp_p[c - 10]);
            @(negedge clk);
            check($sformatf("s3_resume_req_ready_c%0d", c), 64'(req_ready), 64'd1 << (c - 10));
`ifdef MUL_ARB_PERF_EN
            if (c == 10) begin
                check("s3_perf_issue", 64'(perf_issue_cnt), 64'd4);
                check("s3_perf_stall", 64'(perf_stall_cnt), 64'd6);
            end
`endif
            next_cycle();
        end
        drain("s3");

        // Operand extremes through requester 0.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        set_op(0, 32'h8000_0000, 32'h8000_0000);
        push(0, 64'h4000_0000_0000_0000);
        @(negedge clk);
        check("s4_req_ready_0", 64'(req_ready), 64'b0001);
        next_cycle();
        set_op(0, 32'h8000_0000, 32'd1);
        push(0, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        check("s4_req_ready_1", 64'(req_ready), 64'b0001);
        next_cycle();
        set_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        push(0, 64'hFFFF_FFFF_8000_0001);
        @(negedge clk);
        check("s4_req_ready_2", 64'(req_ready), 64'b0001);
        next_cycle();
        drain("s4");

        // Reset with products in flight and one in the FIFO.
        do_reset();
        load_table();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("s5_req_ready_c%0d", c), 64'(req_ready), 64'd1 << c);
            next_cycle();
        end
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("s5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("s5_rst_req_ready", 64'(req_ready), 64'd0);
        check("s5_rst_mul_a", 64'(mul_a), 64'd0);
        check("s5_rst_mul_b", 64'(mul_b), 64'd0);
        check("s5_rst_rsp_prod", rsp_prod, 64'd0);
        next_cycle();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("s5_no_stale_c%0d", c), 64'(rsp_valid), 64'd0);
            next_cycle();
        end
        req_valid = 4'b1111;
        push(0, exp_p[0]);
        @(negedge clk);
        check("s5_rr_restart", 64'(req_ready), 64'b0001);
        next_cycle();
        drain("s5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
